// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD up/down counter with validated synchronous load,
// registered wrap/load-error pulses and a combinational terminal count.
module bcd_counter_n #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  carry,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] count_reg, count_next, step_val;
  logic                carry_reg, carry_next;
  logic                load_err_reg, load_err_next;
  logic [DIGITS:0]     below9, below0;
  logic [DIGITS-1:0]   nib_bad;

  // below9[i]/below0[i]: every digit under position i is 9 / 0 (ripple enable)
  assign below9[0] = 1'b1;
  assign below0[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] inc_val, dec_val;

      assign digit          = count_reg[4*gi +: 4];
      assign below9[gi+1]   = below9[gi] & (digit == 4'd9);
      assign below0[gi+1]   = below0[gi] & (digit == 4'd0);
      assign inc_val        = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      assign dec_val        = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      assign step_val[4*gi +: 4] = up ? (below9[gi] ? inc_val : digit)
                                      : (below0[gi] ? dec_val : digit);
      assign nib_bad[gi]    = (load_val[4*gi +: 4] > 4'd9);
    end
  endgenerate

  always_comb begin
    count_next    = count_reg;
    carry_next    = 1'b0;
    load_err_next = 1'b0;
    if (load) begin
      // A rejected load leaves the count untouched so a bad value never lands
      if (|nib_bad)
        load_err_next = 1'b1;
      else
        count_next = load_val;
    end else if (en) begin
      count_next = step_val;
      carry_next = up ? below9[DIGITS] : below0[DIGITS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= '0;
      carry_reg    <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      carry_reg    <= carry_next;
      load_err_reg <= load_err_next;
    end
  end

  // Terminal count ignores load so cascaded stages see a pure carry chain
  assign tc       = en & (up ? below9[DIGITS] : below0[DIGITS]);
  assign count    = count_reg;
  assign carry    = carry_reg;
  assign load_err = load_err_reg;

endmodule
